seven_seg_axil_responder: RTL
=============================

// Module: seven_seg_axil_responder
// PURPOSE
//  AXI4-Lite responder (slave) holding four 32-bit registers that drive a multiplexed four-digit seven-segment display.
//  Sits behind the interconnect, opposite the AXI4-Lite master BFM.
//  Answers single-beat writes/reads with OKAY and scans digits continuously from register contents.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32     data bus width; only 32 supported
//  C_S_AXI_ADDR_WIDTH  4      byte address width; bits [3:2] select register
//  SCAN_DIV_RST        50000  reset value of SCAN_DIV (clocks per digit slot)
// PORTS
//  ACLK           in   1   single clock; all logic rising-edge
//  ARESET         in   1   reset: asynchronous, active-high
//  S_AXI_AWADDR   in   4   write address
//  S_AXI_AWPROT   in   3   ignored
//  S_AXI_AWVALID  in   1   / S_AXI_AWREADY out 1   write address handshake
//  S_AXI_WDATA    in   32  write data
//  S_AXI_WSTRB    in   4   byte strobes
//  S_AXI_WVALID   in   1   / S_AXI_WREADY  out 1   write data handshake
//  S_AXI_BRESP    out  2   always 2'b00
//  S_AXI_BVALID   out  1   / S_AXI_BREADY  in  1   write response handshake
//  S_AXI_ARADDR   in   4   read address
//  S_AXI_ARPROT   in   3   ignored
//  S_AXI_ARVALID  in   1   / S_AXI_ARREADY out 1   read address handshake
//  S_AXI_RDATA    out  32  read data
//  S_AXI_RRESP    out  2   always 2'b00
//  S_AXI_RVALID   out  1   / S_AXI_RREADY  in  1   read data handshake
//  SEG_N          out  7   segments g..a, active-low
//  DP_N           out  1   decimal point, active-low
//  AN_N           out  4   digit anodes, active-low, one-hot-low
// BEHAVIOUR
//  Reset: all READY/VALID 0, RDATA 0, REG0/1/3 = 0, REG2 = SCAN_DIV_RST, scan idx 0, AN_N=4'hF, SEG_N=7'h7F, DP_N=1.
//  Registers (all 32-bit fully RW, byte-strobed): 0x0 DIGITS [15:0] four hex nibbles, digit0 = [3:0];
//   0x4 CTRL [3:0] digit enable, [7:4] DP per digit, [8] raw mode; 0x8 SCAN_DIV [15:0];
//   0xC RAW [27:0] seven bits per digit (raw mode). Unused bits store and read back.
//  Write: AW and W accepted independently; each one-deep holding slot; READY=1 while slot empty and BVALID=0.
//   Commit the cycle both slots full: REG[addr[3:2]] byte i <= WDATA byte i where WSTRB[i]; BVALID=1 next cycle.
//   BVALID held until BREADY; both slots then clear; no new AW/W accepted while BVALID=1.
//   AW and W together on an idle bus: commit next cycle, BVALID 2 cycles after handshake.
//  Read: ARREADY=1 when RVALID=0; on AR handshake RDATA <= REG[araddr[3:2]], RVALID=1 next cycle (latency 1).
//   RDATA/RVALID stable until RREADY. Reads/writes run concurrently.
//   Same-cycle read sample and write commit to one register: read returns pre-write value.
//  Scan: 16-bit counter runs 0..SCAN_DIV; at terminal count wraps to 0 and idx advances 0-1-2-3-0.
//   SCAN_DIV=0 -> advance every cycle. SCAN_DIV written mid-count: counter >= new value wraps on next cycle.
//  Outputs registered, 1 cycle after idx change: AN_N[idx]=0 only if CTRL[idx]=1, else all 1.
//   SEG_N = ~hexdecode(DIGITS nibble idx), or ~RAW[7*idx+:7] in raw mode. DP_N = ~CTRL[4+idx].
//  Reset asserted mid-transaction: all channels drop VALID/READY immediately; pending beats discarded.
// STRUCTURE
//  Package seven_seg_pkg: register offsets, CTRL bit indices, RESP_OKAY, 16-entry hex->segment table function.
//  One sub-module seven_seg_scanner (divider, idx, decode, output regs); AXI channel logic in top.
// TESTING
//  1 Write 0x0101FFFF/0xABCD0001/0xDEAD0011/0xBEEF0011 to 0x0/0x4/0x8/0xC -> each BRESP OKAY, readback exact.
//  2 Write 0x12345678 WSTRB=4'b0101 to 0x0 holding 0 -> read 0x00340078.
//  3 W leads AW by 3 cycles, BREADY held low 5 cycles -> single commit, BVALID stays 1, no second AW accepted.
//  4 DIGITS=0x0000_3210, CTRL=0x0000_002F, SCAN_DIV=3 -> AN_N cycles E,D,B,7 every 4 clocks;
//    SEG_N 0x40,0x79,0x24,0x30; DP_N=0 only on digit1.
//  5 Read 0x4 same cycle a write to 0x4 commits -> RDATA old value; following read returns new.
//  6 Assert ARESET with BVALID and RVALID high -> both 0 next edge, registers at reset values, AN_N=4'hF.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared constants and the hex-to-segment table for the seven-segment responder.
package seven_seg_pkg;

    localparam logic [1:0] REG_DIGITS   = 2'd0;
    localparam logic [1:0] REG_CTRL     = 2'd1;
    localparam logic [1:0] REG_SCAN_DIV = 2'd2;
    localparam logic [1:0] REG_RAW      = 2'd3;

    localparam int CTRL_EN_LSB = 0;
    localparam int CTRL_DP_LSB = 4;
    localparam int CTRL_RAW    = 8;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Active-high segments, bit 6 = g down to bit 0 = a.
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: digit-slot divider, scan index and registered active-low display outputs.
module seven_seg_scanner
    import seven_seg_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digits_i,
    input  logic [8:0]  ctrl_i,
    input  logic [15:0] scan_div_i,
    input  logic [27:0] raw_i,
    output logic [6:0]  seg_n_o,
    output logic        dp_n_o,
    output logic [3:0]  an_n_o
);

    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;
    logic [6:0]  seg_n_q, seg_n_d;
    logic        dp_n_q, dp_n_d;
    logic [3:0]  an_n_q, an_n_d;
    logic        wrap;

    // ">=" lets a shrinking SCAN_DIV take effect on the very next cycle.
    always_comb begin
        wrap    = cnt_q >= scan_div_i;
        cnt_d   = wrap ? 16'd0 : cnt_q + 16'd1;
        idx_d   = wrap ? idx_q + 2'd1 : idx_q;
        an_n_d  = ctrl_i[CTRL_EN_LSB + int'(idx_q)] ? ~(4'b0001 << idx_q) : 4'hF;
        seg_n_d = ctrl_i[CTRL_RAW] ? ~raw_i[7*int'(idx_q) +: 7] : ~hex_seg(digits_i[4*int'(idx_q) +: 4]);
        dp_n_d  = ~ctrl_i[CTRL_DP_LSB + int'(idx_q)];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            an_n_q  <= 4'hF;
            seg_n_q <= 7'h7F;
            dp_n_q  <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_n_q  <= an_n_d;
            seg_n_q <= seg_n_d;
            dp_n_q  <= dp_n_d;
        end
    end

    assign seg_n_o = seg_n_q;
    assign dp_n_o  = dp_n_q;
    assign an_n_o  = an_n_q;

endmodule

// File: rtl/seven_seg_axil_responder.sv
// seven_seg_axil_responder: AXI4-Lite register block driving a multiplexed four-digit seven-segment display.
module seven_seg_axil_responder
    import seven_seg_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 4,
    parameter logic [31:0] SCAN_DIV_RST       = 32'd50000
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [6:0]                      SEG_N,
    output logic                            DP_N,
    output logic [3:0]                      AN_N
);

    logic [31:0] regs_q [4];
    logic [31:0] regs_d [4];
    logic        aw_full_q, aw_full_d, w_full_q, w_full_d;
    logic [1:0]  aw_addr_q, aw_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [3:0]  w_strb_q, w_strb_d;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        aw_hs, w_hs, ar_hs;
    logic        unused;

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Readies are gated by reset so every channel goes quiet the instant ARESET rises.
    assign S_AXI_AWREADY = ~ARESET & ~aw_full_q & ~bvalid_q;
    assign S_AXI_WREADY  = ~ARESET & ~w_full_q & ~bvalid_q;
    assign S_AXI_ARREADY = ~ARESET & ~rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

    always_comb begin
        regs_d    = regs_q;
        aw_full_d = aw_hs ? 1'b1 : aw_full_q;
        aw_addr_d = aw_hs ? S_AXI_AWADDR[3:2] : aw_addr_q;
        w_full_d  = w_hs ? 1'b1 : w_full_q;
        w_data_d  = w_hs ? S_AXI_WDATA : w_data_q;
        w_strb_d  = w_hs ? S_AXI_WSTRB : w_strb_q;
        bvalid_d  = bvalid_q & ~S_AXI_BREADY;
        // Slots are freed at commit; BVALID alone then holds off new beats.
        if (aw_full_q && w_full_q) begin
            for (int i = 0; i < 4; i++)
                if (w_strb_q[i]) regs_d[aw_addr_q][8*i +: 8] = w_data_q[8*i +: 8];
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
        end
        rvalid_d = ar_hs | (rvalid_q & ~S_AXI_RREADY);
        rdata_d  = ar_hs ? regs_q[S_AXI_ARADDR[3:2]] : rdata_q;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            regs_q    <= '{32'd0, 32'd0, SCAN_DIV_RST, 32'd0};
            aw_full_q <= 1'b0;
            aw_addr_q <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            aw_full_q <= aw_full_d;
            aw_addr_q <= aw_addr_d;
            w_full_q  <= w_full_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
        end
    end

    seven_seg_scanner u_scanner (
        .clk        (ACLK),
        .rst        (ARESET),
        .digits_i   (regs_q[REG_DIGITS][15:0]),
        .ctrl_i     (regs_q[REG_CTRL][8:0]),
        .scan_div_i (regs_q[REG_SCAN_DIV][15:0]),
        .raw_i      (regs_q[REG_RAW][27:0]),
        .seg_n_o    (SEG_N),
        .dp_n_o     (DP_N),
        .an_n_o     (AN_N)
    );

endmodule
